xor_parity_pipe: RTL and testbench
==================================

Name: xor_parity_pipe

Overview:
- Parametrised, pipelined successor to the 2-input XOR cell.
- Reduces a WIDTH-bit data beat to 1 parity bit, accumulates parity across a multi-beat frame, and emits one result per frame with a beat count.
- Valid/ready on both sides. Used as a streaming parity generator for datapath and bus integrity logic built on the 9-track library.

Parameters:
- WIDTH, 32, data beat width in bits (>=2).
- STAGES, 2, register stages from input accept to OUT_VALID (>=1); the last stage is the accumulator/output stage.
- CNT_W, 8, width of the beat counter and OUT_BEATS; the counter saturates.
- ODD, 0, 0 = even parity (result is the XOR of all bits); 1 = odd (result inverted).

Ports:
- CLK  input  1  rising-edge clock
- RN  input  1  asynchronous active-low reset
- IN_VALID  input  1  beat present
- IN_READY  output  1  beat accepted when IN_VALID&IN_READY at a CLK edge
- IN_DATA  input  WIDTH  beat data
- IN_LAST  input  1  final beat of the frame
- OUT_VALID  output  1  frame result present
- OUT_READY  input  1  result consumed when OUT_VALID&OUT_READY
- OUT_PARITY  output  1  frame parity
- OUT_BEATS  output  CNT_W  beats in the frame, saturating

Behaviour:
- Interface decision: one clock, CLK; reset is asynchronous and active-low, RN.
- RN low clears immediately: all stage valids, accumulator, counter, OUT_VALID, OUT_PARITY and OUT_BEATS go to 0. A partial frame in flight is discarded. After RN rises, the first accepted beat starts a new frame.
- Stall: advance = !(OUT_VALID & !OUT_READY).
- IN_READY = advance. This is combinational from OUT_VALID/OUT_READY only and never depends on IN_VALID.
- When advance=1, every stage shifts by one each cycle. When advance=0, all stages hold and no beat is accepted.
- Stage 1 registers the parity of IN_DATA (XOR reduction), IN_LAST and valid.
- Stages 2..STAGES-1 are pure delay. The reduction tree may be split across them, but the result must be bit-exact.
- Final stage, on a valid beat p with advance=1:
  - Not last: acc <= acc^p; cnt <= sat(cnt+1).
  - Last: OUT_PARITY <= acc^p^ODD; OUT_BEATS <= sat(cnt+1); OUT_VALID <= 1; acc <= 0; cnt <= 0.
- Accumulator states: IDLE (cnt=0) moves to ACCUM on a non-last beat. ACCUM returns to IDLE on a last beat.
- A single-beat frame (IN_LAST on the first beat) goes IDLE to IDLE and produces a result.
- Latency: OUT_VALID rises STAGES cycles after the accepting edge of the last beat, provided there are no stalls.
- Output handshake:
  - OUT_VALID&OUT_READY with no new result in the same cycle: OUT_VALID <= 0.
  - Consume and new result in the same cycle: the new result is loaded and OUT_VALID stays 1.
  - Back-to-back frames run with no bubble.
- While OUT_VALID=1, OUT_PARITY and OUT_BEATS are stable until consumed.
- Saturation: cnt holds at 2^CNT_W-1. The accumulator keeps XORing regardless.
- Invalid (bubble) beats never change acc or cnt.

Optional Feature:
- Macro XOR_PARITY_CHECK_EN.
- When defined, ports are added:
  - IN_EXP, input, 1: expected frame parity, sampled on the accepted last beat and carried through the pipeline.
  - OUT_ERR, output, 1: (computed frame parity) ^ IN_EXP. It is valid with OUT_VALID and is reset to 0.
- When undefined, these ports and registers are absent. All other behaviour is identical.

Test Plan:
- WIDTH=8, STAGES=2, ODD=0: single beat 0x07 with IN_LAST accepted at edge 0 -> OUT_VALID=1 after edge 2, OUT_PARITY=1, OUT_BEATS=1.
- Frame 0x01, 0x03, 0x80 (last), OUT_READY=1 -> OUT_PARITY=0, OUT_BEATS=3. Repeat with ODD=1 -> OUT_PARITY=1.
- Back-to-back frames {0x01 last}, {0xFF last} with OUT_READY=1 -> results 1 then 0 on consecutive cycles; IN_READY stays 1 throughout.
- Backpressure: OUT_READY=0 while a result is valid -> IN_READY=0, OUT_PARITY and OUT_BEATS held 5 cycles. OUT_READY=1 -> consumed, IN_READY=1 the same cycle.
- CNT_W=4: 20-beat frame of 0x01 -> OUT_BEATS=15, OUT_PARITY=0.
- RN pulsed low after 2 beats of a frame (async, mid-cycle) -> all outputs 0 at once. Then frame {0x01 last} -> OUT_PARITY=1, OUT_BEATS=1. With XOR_PARITY_CHECK_EN and IN_EXP=0 -> OUT_ERR=1.

Source files
------------

// File: rtl/xor_parity_pipe.sv
// xor_parity_pipe: streaming frame parity generator with valid/ready on both sides.
// Defining XOR_PARITY_CHECK_EN adds IN_EXP/OUT_ERR expected-parity checking.
module xor_parity_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2,
    parameter int CNT_W  = 8,
    parameter int ODD    = 0
) (
    input  logic             CLK,
    input  logic             RN,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] IN_DATA,
    input  logic             IN_LAST,
`ifdef XOR_PARITY_CHECK_EN
    input  logic             IN_EXP,
    output logic             OUT_ERR,
`endif
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic             OUT_PARITY,
    output logic [CNT_W-1:0] OUT_BEATS
);

    localparam logic LP_ODD = (ODD != 0);

    typedef enum logic {S_IDLE, S_ACCUM} state_t;

    logic [STAGES-1:0] r_vld;
    logic [STAGES-1:0] r_par;
    logic [STAGES-1:0] r_last;
    logic              r_acc;
    logic [CNT_W-1:0]  r_cnt;
    state_t            r_state;
    state_t            w_stateNext;
    logic [CNT_W-1:0]  w_cntBase;
    logic [CNT_W-1:0]  w_cntInc;
    logic              w_advance;
    logic              w_tailVld;
    logic              w_tailPar;
    logic              w_tailLast;
    logic              w_frameParity;

    // A held, unconsumed result freezes every stage, so ready never looks at IN_VALID.
    assign w_advance  = !(OUT_VALID && !OUT_READY);
    assign IN_READY   = w_advance;
    assign w_tailVld  = r_vld[STAGES-1];
    assign w_tailPar  = r_par[STAGES-1];
    assign w_tailLast = r_last[STAGES-1];

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            r_vld  <= '0;
            r_par  <= '0;
            r_last <= '0;
        end else if (w_advance) begin
            r_vld[0]  <= IN_VALID;
            r_par[0]  <= ^IN_DATA;
            r_last[0] <= IN_LAST;
            for (int i = 1; i < STAGES; i++) begin
                r_vld[i]  <= r_vld[i-1];
                r_par[i]  <= r_par[i-1];
                r_last[i] <= r_last[i-1];
            end
        end
    end

    always_comb begin
        w_stateNext   = r_state;
        w_cntBase     = r_cnt;
        if (r_state == S_IDLE) begin
            w_cntBase = '0;
        end
        w_cntInc      = (&w_cntBase) ? w_cntBase : w_cntBase + CNT_W'(1);
        w_frameParity = r_acc ^ w_tailPar ^ LP_ODD;
        if (w_advance && w_tailVld) begin
            w_stateNext = w_tailLast ? S_IDLE : S_ACCUM;
        end
    end

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            r_state    <= S_IDLE;
            r_acc      <= 1'b0;
            r_cnt      <= '0;
            OUT_VALID  <= 1'b0;
            OUT_PARITY <= 1'b0;
            OUT_BEATS  <= '0;
        end else begin
            r_state <= w_stateNext;
            if (w_advance) begin
                if (w_tailVld && w_tailLast) begin
                    OUT_PARITY <= w_frameParity;
                    OUT_BEATS  <= w_cntInc;
                    OUT_VALID  <= 1'b1;
                    r_acc      <= 1'b0;
                    r_cnt      <= '0;
                end else begin
                    OUT_VALID <= 1'b0;
                    if (w_tailVld) begin
                        r_acc <= r_acc ^ w_tailPar;
                        r_cnt <= w_cntInc;
                    end
                end
            end
        end
    end

`ifdef XOR_PARITY_CHECK_EN
    logic [STAGES-1:0] r_exp;
    logic              w_tailExp;

    assign w_tailExp = r_exp[STAGES-1];

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            r_exp   <= '0;
            OUT_ERR <= 1'b0;
        end else if (w_advance) begin
            r_exp[0] <= IN_EXP;
            for (int i = 1; i < STAGES; i++) begin
                r_exp[i] <= r_exp[i-1];
            end
            if (w_tailVld && w_tailLast) begin
                OUT_ERR <= w_frameParity ^ w_tailExp;
            end
        end
    end
`endif

endmodule

// File: tb/tb_xor_parity_pipe.sv
// tb_xor_parity_pipe: directed and randomized frames against a queue-based parity model.
// Two instances share stimulus: even parity (u_even) and odd parity (u_odd).
module tb_xor_parity_pipe;

    localparam int WIDTH  = 8;
    localparam int STAGES = 2;
    localparam int CNT_W  = 4;
    localparam int SAT    = (1 << CNT_W) - 1;

    typedef struct {
        logic             par;
        logic [CNT_W-1:0] beats;
        logic             err;
    } result_t;

    logic             CLK;
    logic             RN;
    logic             IN_VALID;
    logic [WIDTH-1:0] IN_DATA;
    logic             IN_LAST;
    logic             OUT_READY;
    logic             IN_READY;
    logic             OUT_VALID;
    logic             OUT_PARITY;
    logic [CNT_W-1:0] OUT_BEATS;
    logic             oddInReady;
    logic             oddOutValid;
    logic             oddOutParity;
    logic [CNT_W-1:0] oddOutBeats;
    logic             curExp;
`ifdef XOR_PARITY_CHECK_EN
    logic             OUT_ERR;
    logic             oddOutErr;
`endif

    int      checks = 0;
    int      errors = 0;
    bit      rndMode = 0;
    bit      rndReady = 0;
    bit      flushReq = 0;
    result_t expQ[$];
    bit      modelPar = 0;
    int      modelCnt = 0;
    bit      holdPending = 0;
    logic    holdPar;
    logic [CNT_W-1:0] holdBeats;

    xor_parity_pipe #(.WIDTH(WIDTH), .STAGES(STAGES), .CNT_W(CNT_W), .ODD(0)) u_even (
        .CLK(CLK), .RN(RN), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .IN_DATA(IN_DATA), .IN_LAST(IN_LAST),
`ifdef XOR_PARITY_CHECK_EN
        .IN_EXP(curExp), .OUT_ERR(OUT_ERR),
`endif
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
        .OUT_PARITY(OUT_PARITY), .OUT_BEATS(OUT_BEATS)
    );

    xor_parity_pipe #(.WIDTH(WIDTH), .STAGES(STAGES), .CNT_W(CNT_W), .ODD(1)) u_odd (
        .CLK(CLK), .RN(RN), .IN_VALID(IN_VALID), .IN_READY(oddInReady),
        .IN_DATA(IN_DATA), .IN_LAST(IN_LAST),
`ifdef XOR_PARITY_CHECK_EN
        .IN_EXP(curExp), .OUT_ERR(oddOutErr),
`endif
        .OUT_VALID(oddOutValid), .OUT_READY(OUT_READY),
        .OUT_PARITY(oddOutParity), .OUT_BEATS(oddOutBeats)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Inputs change 2-3 ns after the rising edge, well clear of both clock edges.
    task automatic stepCycle();
        @(posedge CLK);
        #2;
        if (rndReady) OUT_READY = ($urandom_range(0, 3) != 0);
        #1;
    endtask

    task automatic applyStimulus(input logic [WIDTH-1:0] data, input logic last, input logic exp);
        bit ok;
        int n;
        if (rndMode) begin
            while ($urandom_range(0, 3) == 0) begin
                IN_VALID = 1'b0;
                stepCycle();
            end
        end
        IN_VALID = 1'b1;
        IN_DATA  = data;
        IN_LAST  = last;
        curExp   = exp;
        n = 0;
        do begin
            ok = IN_READY;
            stepCycle();
            n++;
        end while (!ok && n < 200);
        if (!ok) checkOutput("accept_timeout", 32'(ok), 32'd1);
        IN_VALID = 1'b0;
    endtask

    task automatic waitValid();
        int n;
        n = 0;
        while (!OUT_VALID && n < 60) begin
            stepCycle();
            n++;
        end
        checkOutput("wait_valid", 32'(OUT_VALID), 32'd1);
    endtask

    // Reference model: frame parity from popcount, saturating beat count, checked on each consume.
    always @(negedge CLK) begin
        result_t r;
        if (flushReq) begin
            expQ.delete();
            modelPar    = 0;
            modelCnt    = 0;
            holdPending = 0;
            flushReq    = 0;
        end
        if (RN) begin
            checkOutput("in_ready_rule", 32'(IN_READY), 32'(!(OUT_VALID && !OUT_READY)));
            if (holdPending) begin
                checkOutput("hold_valid", 32'(OUT_VALID), 32'd1);
                checkOutput("hold_parity", 32'(OUT_PARITY), 32'(holdPar));
                checkOutput("hold_beats", 32'(OUT_BEATS), 32'(holdBeats));
            end
            holdPending = OUT_VALID && !OUT_READY;
            holdPar     = OUT_PARITY;
            holdBeats   = OUT_BEATS;
            if (OUT_VALID && OUT_READY) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_result", 32'(expQ.size()), 32'd1);
                end else begin
                    r = expQ.pop_front();
                    checkOutput("model_parity", 32'(OUT_PARITY), 32'(r.par));
                    checkOutput("model_beats", 32'(OUT_BEATS), 32'(r.beats));
                    checkOutput("model_odd_valid", 32'(oddOutValid), 32'd1);
                    checkOutput("model_odd_parity", 32'(oddOutParity), 32'(!r.par));
                    checkOutput("model_odd_beats", 32'(oddOutBeats), 32'(r.beats));
`ifdef XOR_PARITY_CHECK_EN
                    checkOutput("model_err", 32'(OUT_ERR), 32'(r.err));
                    checkOutput("model_odd_err", 32'(oddOutErr), 32'(!r.err));
`endif
                end
            end
            if (IN_VALID && IN_READY) begin
                modelPar = modelPar ^ bit'($countones(IN_DATA) % 2);
                modelCnt++;
                if (IN_LAST) begin
                    r.par   = modelPar;
                    r.beats = CNT_W'((modelCnt > SAT) ? SAT : modelCnt);
                    r.err   = modelPar ^ curExp;
                    expQ.push_back(r);
                    modelPar = 0;
                    modelCnt = 0;
                end
            end
        end
    end

    initial begin
        int len;
        RN = 1'b0; IN_VALID = 1'b0; IN_DATA = '0; IN_LAST = 1'b0; OUT_READY = 1'b1; curExp = 1'b0;
        #2;
        checkOutput("reset_valid", 32'(OUT_VALID), 32'd0);
        checkOutput("reset_parity", 32'(OUT_PARITY), 32'd0);
        checkOutput("reset_beats", 32'(OUT_BEATS), 32'd0);
        checkOutput("reset_in_ready", 32'(IN_READY), 32'd1);
        @(posedge CLK); #3; RN = 1'b1;
        repeat (2) stepCycle();

        // Single beat 0x07: result appears two edges after the accepting edge.
        applyStimulus(8'h07, 1'b1, 1'b1);
        checkOutput("lat_edge0", 32'(OUT_VALID), 32'd0);
        stepCycle();
        checkOutput("lat_edge1", 32'(OUT_VALID), 32'd0);
        stepCycle();
        checkOutput("lat_edge2", 32'(OUT_VALID), 32'd1);
        checkOutput("single_parity", 32'(OUT_PARITY), 32'd1);
        checkOutput("single_beats", 32'(OUT_BEATS), 32'd1);
        repeat (2) stepCycle();

        applyStimulus(8'h01, 1'b0, 1'b0);
        applyStimulus(8'h03, 1'b0, 1'b0);
        applyStimulus(8'h80, 1'b1, 1'b0);
        waitValid();
        checkOutput("frame3_parity", 32'(OUT_PARITY), 32'd0);
        checkOutput("frame3_beats", 32'(OUT_BEATS), 32'd3);
        checkOutput("frame3_odd_parity", 32'(oddOutParity), 32'd1);
        repeat (2) stepCycle();

        // Back-to-back single-beat frames produce results on consecutive cycles.
        checkOutput("b2b_ready_a", 32'(IN_READY), 32'd1);
        applyStimulus(8'h01, 1'b1, 1'b1);
        checkOutput("b2b_ready_b", 32'(IN_READY), 32'd1);
        applyStimulus(8'hFF, 1'b1, 1'b0);
        checkOutput("b2b_ready_c", 32'(IN_READY), 32'd1);
        stepCycle();
        checkOutput("b2b_valid_a", 32'(OUT_VALID), 32'd1);
        checkOutput("b2b_parity_a", 32'(OUT_PARITY), 32'd1);
        checkOutput("b2b_ready_d", 32'(IN_READY), 32'd1);
        stepCycle();
        checkOutput("b2b_valid_b", 32'(OUT_VALID), 32'd1);
        checkOutput("b2b_parity_b", 32'(OUT_PARITY), 32'd0);
        checkOutput("b2b_beats_b", 32'(OUT_BEATS), 32'd1);
        stepCycle();
        checkOutput("b2b_drained", 32'(OUT_VALID), 32'd0);

        OUT_READY = 1'b0;
        applyStimulus(8'h03, 1'b0, 1'b1);
        applyStimulus(8'h01, 1'b1, 1'b1);
        waitValid();
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp_in_ready", 32'(IN_READY), 32'd0);
            checkOutput("bp_parity", 32'(OUT_PARITY), 32'd1);
            checkOutput("bp_beats", 32'(OUT_BEATS), 32'd2);
            stepCycle();
        end
        OUT_READY = 1'b1;
        #1;
        checkOutput("bp_release_ready", 32'(IN_READY), 32'd1);
        stepCycle();
        checkOutput("bp_consumed", 32'(OUT_VALID), 32'd0);

        for (int i = 0; i < 20; i++) applyStimulus(8'h01, (i == 19), 1'b0);
        waitValid();
        checkOutput("sat_parity", 32'(OUT_PARITY), 32'd0);
        checkOutput("sat_beats", 32'(OUT_BEATS), 32'd15);
        repeat (2) stepCycle();

        // Hold a result, leave two beats of a new frame in flight, then pulse RN mid-cycle.
        OUT_READY = 1'b0;
        applyStimulus(8'h01, 1'b1, 1'b0);
        applyStimulus(8'h01, 1'b0, 1'b0);
        applyStimulus(8'h01, 1'b0, 1'b0);
        checkOutput("pre_rst_valid", 32'(OUT_VALID), 32'd1);
        RN = 1'b0;
        #1;
        checkOutput("rst_valid", 32'(OUT_VALID), 32'd0);
        checkOutput("rst_parity", 32'(OUT_PARITY), 32'd0);
        checkOutput("rst_beats", 32'(OUT_BEATS), 32'd0);
        checkOutput("rst_odd_valid", 32'(oddOutValid), 32'd0);
        checkOutput("rst_odd_parity", 32'(oddOutParity), 32'd0);
        checkOutput("rst_in_ready", 32'(IN_READY), 32'd1);
`ifdef XOR_PARITY_CHECK_EN
        checkOutput("rst_err", 32'(OUT_ERR), 32'd0);
`endif
        flushReq = 1'b1;
        RN = 1'b1;
        OUT_READY = 1'b1;
        stepCycle();
        applyStimulus(8'h01, 1'b1, 1'b0);
        waitValid();
        checkOutput("post_rst_parity", 32'(OUT_PARITY), 32'd1);
        checkOutput("post_rst_beats", 32'(OUT_BEATS), 32'd1);
`ifdef XOR_PARITY_CHECK_EN
        checkOutput("post_rst_err", 32'(OUT_ERR), 32'd1);
`endif
        repeat (2) stepCycle();

        rndMode  = 1'b1;
        rndReady = 1'b1;
        for (int f = 0; f < 60; f++) begin
            len = ($urandom_range(0, 7) == 0) ? int'($urandom_range(16, 20)) : int'($urandom_range(1, 5));
            for (int b = 0; b < len; b++) begin
                applyStimulus(WIDTH'($urandom), (b == len - 1), 1'($urandom));
            end
        end
        rndMode   = 1'b0;
        rndReady  = 1'b0;
        OUT_READY = 1'b1;
        for (int n = 0; n < 100 && (expQ.size() != 0 || OUT_VALID); n++) stepCycle();
        checkOutput("drain_queue_empty", 32'(expQ.size()), 32'd0);
        checkOutput("drain_valid", 32'(OUT_VALID), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
